// File: rtl/cla_operand_sequencer.sv
// Operand sequencer around an external combinational adder: collects A then B, waits one
// settle cycle, captures sum plus reconstructed carry-out, and holds it until the sink accepts.
module cla_operand_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic             clk_pi,
  input  logic             rst_n_pi,
  input  logic [WIDTH-1:0] op_data_pi,
  input  logic             op_valid_pi,
  output logic             op_ready_po,
  output logic [WIDTH-1:0] add_a_po,
  output logic [WIDTH-1:0] add_b_po,
  input  logic [WIDTH-1:0] add_sum_pi,
  output logic [WIDTH-1:0] res_data_po,
  output logic             res_carry_po,
  output logic             res_valid_po,
  input  logic             res_ready_pi,
  output logic [7:0]       op_count_po
);

  typedef enum logic [2:0] {
    LOAD_A  = 3'd0,
    LOAD_B  = 3'd1,
    SETTLE  = 3'd2,
    CAPTURE = 3'd3,
    HOLD    = 3'd4
  } state_t;

  state_t           state_q;
  logic             op_ready_q;
  logic [WIDTH-1:0] add_a_q;
  logic [WIDTH-1:0] add_b_q;
  logic [WIDTH-1:0] res_data_q;
  logic             res_carry_q;
  logic             res_valid_q;
  logic [7:0]       op_count_q;

  logic             op_fire;
  logic             res_fire;
  logic             carry_d;

  assign op_fire  = op_valid_pi & op_ready_q;
  assign res_fire = res_valid_q & res_ready_pi;

  // The adder returns only WIDTH bits; recover the carry from the operand and sum MSBs.
  assign carry_d = (add_a_q[WIDTH-1] & add_b_q[WIDTH-1]) |
                   ((add_a_q[WIDTH-1] | add_b_q[WIDTH-1]) & ~add_sum_pi[WIDTH-1]);

  always_ff @(posedge clk_pi or negedge rst_n_pi) begin
    if (!rst_n_pi) begin
      state_q     <= LOAD_A;
      op_ready_q  <= 1'b1;
      add_a_q     <= '0;
      add_b_q     <= '0;
      res_data_q  <= '0;
      res_carry_q <= 1'b0;
      res_valid_q <= 1'b0;
      op_count_q  <= 8'd0;
    end else begin
      case (state_q)
        LOAD_A: begin
          if (op_fire) begin
            add_a_q <= op_data_pi;
            state_q <= LOAD_B;
          end
        end
        LOAD_B: begin
          if (op_fire) begin
            add_b_q    <= op_data_pi;
            op_ready_q <= 1'b0;
            state_q    <= SETTLE;
          end
        end
        SETTLE: begin
          state_q <= CAPTURE;
        end
        CAPTURE: begin
          res_data_q  <= add_sum_pi;
          res_carry_q <= carry_d;
          res_valid_q <= 1'b1;
          op_count_q  <= op_count_q + 8'd1;
          state_q     <= HOLD;
        end
        HOLD: begin
          if (res_fire) begin
            res_valid_q <= 1'b0;
            op_ready_q  <= 1'b1;
            state_q     <= LOAD_A;
          end
        end
        default: begin
          res_valid_q <= 1'b0;
          op_ready_q  <= 1'b1;
          state_q     <= LOAD_A;
        end
      endcase
    end
  end

  assign op_ready_po  = op_ready_q;
  assign add_a_po     = add_a_q;
  assign add_b_po     = add_b_q;
  assign res_data_po  = res_data_q;
  assign res_carry_po = res_carry_q;
  assign res_valid_po = res_valid_q;
  assign op_count_po  = op_count_q;

endmodule
